// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_reg
// Brief    : WIDTH-bit universal shift register with hold, shift right,
//            shift left and parallel load, selected per cycle by a 2-bit
//            operation code. Asynchronous active-high clear.
//            Optional macro USR_ZERO_FLAG_EN adds a combinational
//            zero_flag output that is high while the register is all zeros.
// Revision : 1.0 - initial release
// ============================================================================
module universal_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] p_din,
    input  logic             s_left_din,
    input  logic             s_right_din,
    output logic [WIDTH-1:0] p_dout,
    output logic             s_left_dout,
    output logic             s_right_dout
`ifdef USR_ZERO_FLAG_EN
    ,
    output logic             zero_flag
`endif
);

    localparam logic [1:0] c_OP_HOLD  = 2'b00;
    localparam logic [1:0] c_OP_RIGHT = 2'b01;
    localparam logic [1:0] c_OP_LEFT  = 2'b10;
    localparam logic [1:0] c_OP_LOAD  = 2'b11;

    logic [WIDTH-1:0] r_data;

    // Register update: one operation per edge; unknown codes fall to hold.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_data <= '0;
        end else begin
            case (select)
                c_OP_HOLD:  r_data <= r_data;
                c_OP_RIGHT: r_data <= {s_right_din, r_data[WIDTH-1:1]};
                c_OP_LEFT:  r_data <= {r_data[WIDTH-2:0], s_left_din};
                c_OP_LOAD:  r_data <= p_din;
                default:    r_data <= r_data;
            endcase
        end
    end

    // Outputs are direct taps of the register, no extra pipeline stage.
    assign p_dout       = r_data;
    assign s_left_dout  = r_data[WIDTH-1];
    assign s_right_dout = r_data[0];

`ifdef USR_ZERO_FLAG_EN
    // Zero detect on the live register; high during clear since R is zero.
    assign zero_flag = (r_data == '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_shift_reg
// Brief    : Self-checking bench for universal_shift_reg (WIDTH=4), directed
//            scenarios plus randomized operations against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_universal_shift_reg;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk;
    logic             clr;
    logic [1:0]       select;
    logic [WIDTH-1:0] p_din;
    logic             s_left_din;
    logic             s_right_din;
    logic [WIDTH-1:0] p_dout;
    logic             s_left_dout;
    logic             s_right_dout;
`ifdef USR_ZERO_FLAG_EN
    logic             zero_flag;
`endif

    int n_checks;
    int n_pass;

    universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .clr          (clr),
        .select       (select),
        .p_din        (p_din),
        .s_left_din   (s_left_din),
        .s_right_din  (s_right_din),
        .p_dout       (p_dout),
        .s_left_dout  (s_left_dout),
        .s_right_dout (s_right_dout)
`ifdef USR_ZERO_FLAG_EN
        ,
        .zero_flag    (zero_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        select = 2'b11; p_din = 4'b1101; s_left_din = 1'b1; s_right_din = 1'b0;
        clr = 1'b1;
        #2;
        n_checks++;
        if (p_dout !== 4'b0000) $display("FAIL reset_p_dout: got %b want 0000", p_dout);
        else n_pass++;
        n_checks++;
        if (s_left_dout !== 1'b0 || s_right_dout !== 1'b0)
            $display("FAIL reset_serial: got L=%b R=%b want 0 0", s_left_dout, s_right_dout);
        else n_pass++;
        tick();
        n_checks++;
        if (p_dout !== 4'b0000) $display("FAIL reset_hold_edge: got %b want 0000", p_dout);
        else n_pass++;
    endtask

    task automatic test_shift_right();
        logic [3:0] exp_q [2];
        logic       exp_r [2];
        exp_q[0] = 4'b0110; exp_q[1] = 4'b0011;
        exp_r[0] = 1'b0;    exp_r[1] = 1'b1;
        #1 clr = 1'b0;
        select = 2'b11; p_din = 4'b1101;
        tick();
        n_checks++;
        if (p_dout !== 4'b1101 || s_right_dout !== 1'b1)
            $display("FAIL load_1101: got %b sr=%b want 1101 sr=1", p_dout, s_right_dout);
        else n_pass++;
        select = 2'b01;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (p_dout !== exp_q[i] || s_right_dout !== exp_r[i])
                $display("FAIL shift_right_%0d: got %b sr=%b want %b sr=%b",
                         i, p_dout, s_right_dout, exp_q[i], exp_r[i]);
            else n_pass++;
        end
    endtask

    task automatic test_shift_left();
        logic [3:0] exp_q [2];
        logic       exp_l [2];
        exp_q[0] = 4'b1011; exp_q[1] = 4'b0111;
        exp_l[0] = 1'b1;    exp_l[1] = 1'b0;
        select = 2'b11; p_din = 4'b1101;
        tick();
        select = 2'b10;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (p_dout !== exp_q[i] || s_left_dout !== exp_l[i])
                $display("FAIL shift_left_%0d: got %b sl=%b want %b sl=%b",
                         i, p_dout, s_left_dout, exp_q[i], exp_l[i]);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        select = 2'b00;
        for (int i = 0; i < 2; i++) begin
            p_din = 4'(i == 0 ? 4'b1010 : 4'b0101);
            s_left_din = 1'(i); s_right_din = ~1'(i);
            tick();
            n_checks++;
            if (p_dout !== 4'b0111)
                $display("FAIL hold_%0d: got %b want 0111", i, p_dout);
            else n_pass++;
        end
        s_left_din = 1'b1; s_right_din = 1'b0;
    endtask

    task automatic test_async_reset();
        select = 2'b11; p_din = 4'b1111;
        tick();
        select = 2'b01; s_right_din = 1'b1;
        tick();
        #2 clr = 1'b1;
        #1;
        n_checks++;
        if (p_dout !== 4'b0000)
            $display("FAIL async_clr_now: got %b want 0000", p_dout);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (p_dout !== 4'b0000)
                $display("FAIL async_clr_edge_%0d: got %b want 0000", i, p_dout);
            else n_pass++;
        end
        // First edge after release performs the selected shift from zero.
        #1 clr = 1'b0;
        tick();
        n_checks++;
        if (p_dout !== 4'b1000)
            $display("FAIL first_op_after_clr: got %b want 1000", p_dout);
        else n_pass++;
        s_right_din = 1'b0;
    endtask

    task automatic test_random();
        int unsigned m;
        int unsigned op;
        int unsigned pd;
        int unsigned sl;
        int unsigned sr;
        m = 0;
        clr = 1'b1;
        #2 clr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 3);
            pd = $urandom_range(0, MASK);
            sl = $urandom_range(0, 1);
            sr = $urandom_range(0, 1);
            select = 2'(op); p_din = 4'(pd); s_left_din = 1'(sl); s_right_din = 1'(sr);
            tick();
            if (op == 1)      m = (m / 2) + sr * (1 << (WIDTH - 1));
            else if (op == 2) m = ((m * 2) % (1 << WIDTH)) + sl;
            else if (op == 3) m = pd;
            n_checks++;
            if (p_dout !== 4'(m) || s_left_dout !== 1'(m >> (WIDTH - 1)) ||
                s_right_dout !== 1'(m % 2))
                $display("FAIL random_%0d op=%0d: got %b L=%b R=%b want %b",
                         i, op, p_dout, s_left_dout, s_right_dout, 4'(m));
            else n_pass++;
        end
    endtask

`ifdef USR_ZERO_FLAG_EN
    task automatic test_zero_flag();
        clr = 1'b1;
        #1;
        n_checks++;
        if (zero_flag !== 1'b1) $display("FAIL zero_flag_clr: got %b want 1", zero_flag);
        else n_pass++;
        #1 clr = 1'b0;
        select = 2'b11; p_din = 4'b0001;
        tick();
        n_checks++;
        if (zero_flag !== 1'b0) $display("FAIL zero_flag_loaded: got %b want 0", zero_flag);
        else n_pass++;
        select = 2'b01; s_right_din = 1'b0;
        tick();
        n_checks++;
        if (zero_flag !== 1'b1 || p_dout !== 4'b0000)
            $display("FAIL zero_flag_shift: got zf=%b q=%b want zf=1 q=0000", zero_flag, p_dout);
        else n_pass++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clr = 1'b0; select = 2'b00; p_din = '0; s_left_din = 1'b1; s_right_din = 1'b0;
        test_reset();
        test_shift_right();
        test_shift_left();
        test_hold();
        test_async_reset();
        test_random();
`ifdef USR_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
